// File: rtl/instr_sequencer_pkg.sv
// Shared types and field layout for the instruction sequencer.
// The processor instruction word is {opCode, Rx, Ry}.
package instr_sequencer_pkg;

  localparam int FUNC_W_DEFAULT = 9;
  localparam int DATA_W_DEFAULT = 8;

  localparam int OPCODE_MSB = 8;
  localparam int OPCODE_LSB = 6;
  localparam int RX_MSB     = 5;
  localparam int RX_LSB     = 3;
  localparam int RY_MSB     = 2;
  localparam int RY_LSB     = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/instr_sequencer_if.sv
// Load-side handshake and issue-side bus between a program source and the sequencer.
interface instr_sequencer_if
  import instr_sequencer_pkg::*;
#(
  parameter int FUNC_W = FUNC_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
);
  logic              load_valid;
  logic [FUNC_W-1:0] load_func;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic [FUNC_W-1:0] func_out;
  logic [DATA_W-1:0] data_out;
  logic              issue_valid;

  modport master (
    output load_valid, load_func, load_data,
    input  load_ready, func_out, data_out, issue_valid
  );

  modport slave (
    input  load_valid, load_func, load_data,
    output load_ready, func_out, data_out, issue_valid
  );
endinterface

// File: rtl/instr_sequencer_prog_mem.sv
// Program store: one write port, one registered read port whose output
// register is zeroed when not reading, so it can drive the issue bus directly.
module seq_prog_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 17
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset || !rd_en)
      rd_data <= '0;
    else
      rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/instr_sequencer.sv
// Buffers a short {func, data} program and replays it one entry per clock.
// The read for entry pc is issued one cycle early so output follows start directly.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int FUNC_W = FUNC_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  instr_sequencer_if.slave       bus,
  input  logic                   clear,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = FUNC_W + DATA_W;

  seq_state_e    state_reg;
  logic [AW-1:0] pc_reg;
  logic          accept;
  logic          last;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [WW-1:0] rd_word;

  always_comb begin
    accept  = (state_reg == IDLE) && bus.load_valid && bus.load_ready && !clear;
    last    = ({1'b0, pc_reg} == (count - CW'(1)));
    rd_en   = 1'b0;
    rd_addr = '0;
    case (state_reg)
      IDLE: rd_en = !clear && !accept && start && (count != '0);
      RUN: begin
        rd_en   = !abort && !last;
        rd_addr = pc_reg + AW'(1);
      end
      default: ;
    endcase
  end

  seq_prog_mem #(.DEPTH(DEPTH), .WIDTH(WW)) u_mem (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (accept),
    .wr_addr (count[AW-1:0]),
    .wr_data ({bus.load_func, bus.load_data}),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_word)
  );

  assign bus.func_out = rd_word[WW-1:DATA_W];
  assign bus.data_out = rd_word[DATA_W-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= IDLE;
      pc_reg          <= '0;
      count           <= '0;
      bus.issue_valid <= 1'b0;
      bus.load_ready  <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (clear) begin
            count          <= '0;
            bus.load_ready <= 1'b1;
          end else if (accept) begin
            count          <= count + CW'(1);
            bus.load_ready <= (count + CW'(1)) < CW'(DEPTH);
          end else if (rd_en) begin
            state_reg       <= RUN;
            pc_reg          <= '0;
            busy            <= 1'b1;
            bus.issue_valid <= 1'b1;
            bus.load_ready  <= 1'b0;
          end
        end
        RUN: begin
          // abort wins over completion: no done pulse when both coincide
          if (abort) begin
            state_reg       <= IDLE;
            pc_reg          <= '0;
            busy            <= 1'b0;
            bus.issue_valid <= 1'b0;
            bus.load_ready  <= count < CW'(DEPTH);
          end else if (last) begin
            state_reg       <= DONE;
            pc_reg          <= '0;
            busy            <= 1'b0;
            bus.issue_valid <= 1'b0;
            done            <= 1'b1;
          end else begin
            pc_reg <= pc_reg + AW'(1);
          end
        end
        DONE: begin
          state_reg      <= IDLE;
          bus.load_ready <= count < CW'(DEPTH);
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench: stimulus pushes expected issues/done pulses into queues,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  localparam int DEPTH = 16;
  localparam int FW    = 9;
  localparam int DW    = 8;
  localparam int CW    = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy;
  logic done;
  logic [CW-1:0] count;

  instr_sequencer_if #(.FUNC_W(FW), .DATA_W(DW)) bus ();

  instr_sequencer #(.DEPTH(DEPTH), .FUNC_W(FW), .DATA_W(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .clear (clear),
    .start (start),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .count (count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [FW-1:0] f;
    logic [DW-1:0] d;
    int            c;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   checks = 0;
  int   passes = 0;

  // reference model of the stored program and replay window
  logic [FW-1:0] m_f [DEPTH];
  logic [DW-1:0] m_d [DEPTH];
  int m_n       = 0;
  int run_first = 1;
  int run_last  = 0;
  int idle_at   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
  endtask

  task automatic trim(input int upto);
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].c > upto) void'(exp_q.pop_back());
    while (done_q.size() > 0 && done_q[done_q.size()-1] > upto) void'(done_q.pop_back());
  endtask

  exp_t e;
  always @(negedge clock) begin
    if (cyc >= 1) begin
      if (bus.issue_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL issue_unexpected at cycle %0d: got func %0h data %0h, required none", cyc, bus.func_out, bus.data_out);
        end else begin
          e = exp_q.pop_front();
          check("issue_cycle", cyc, e.c);
          check("func_out", 32'(bus.func_out), 32'(e.f));
          check("data_out", 32'(bus.data_out), 32'(e.d));
        end
      end else begin
        check("idle_outputs_zero", {15'd0, bus.func_out, bus.data_out}, 32'd0);
        if (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
          checks++;
          $display("FAIL issue_missing at cycle %0d: got issue_valid 0, required entry due cycle %0d", cyc, exp_q[0].c);
          void'(exp_q.pop_front());
        end
      end
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          checks++;
          $display("FAIL done_unexpected at cycle %0d: got done 1, required 0", cyc);
        end else begin
          check("done_cycle", cyc, done_q.pop_front());
        end
      end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
        checks++;
        $display("FAIL done_missing at cycle %0d: got done 0, required pulse at cycle %0d", cyc, done_q[0]);
        void'(done_q.pop_front());
      end
    end
  end

  task automatic step(input logic lv, input logic [FW-1:0] f, input logic [DW-1:0] d,
                      input logic cl, input logic st, input logic ab, input logic rs);
    bit idle_m;
    bit run_m;
    exp_t x;
    idle_m = (cyc >= idle_at);
    run_m  = (cyc >= run_first) && (cyc <= run_last);
    check("count", 32'(count), m_n);
    check("load_ready", 32'(bus.load_ready), 32'(idle_m && m_n < DEPTH));
    check("busy", 32'(busy), 32'(run_m));
    bus.load_valid = lv;
    bus.load_func  = f;
    bus.load_data  = d;
    clear = cl;
    start = st;
    abort = ab;
    reset = rs;
    if (rs) begin
      m_n = 0;
      trim(cyc);
      run_last = cyc;
      idle_at  = cyc + 1;
    end else if (idle_m) begin
      if (cl) begin
        m_n = 0;
      end else if (lv && m_n < DEPTH) begin
        m_f[m_n] = f;
        m_d[m_n] = d;
        m_n++;
      end else if (st && m_n > 0) begin
        for (int i = 0; i < m_n; i++) begin
          x.f = m_f[i];
          x.d = m_d[i];
          x.c = cyc + 1 + i;
          exp_q.push_back(x);
        end
        done_q.push_back(cyc + 1 + m_n);
        run_first = cyc + 1;
        run_last  = cyc + m_n;
        idle_at   = cyc + m_n + 2;
      end
    end else if (run_m && ab) begin
      trim(cyc);
      run_last = cyc;
      idle_at  = cyc + 1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [FW-1:0] f, input logic [DW-1:0] d);
    step(1'b1, f, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic go();
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.load_func  = '0;
    bus.load_data  = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_issue_valid", 32'(bus.issue_valid), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_count", 32'(count), 32'd0);
    check("reset_load_ready", 32'(bus.load_ready), 32'd1);

    // three-word program, replayed in load order
    idle(1);
    load(9'h041, 8'h05);
    load(9'h0C8, 8'h00);
    load(9'h1D0, 8'hFF);
    go();
    idle(7);
    check("count_after_replay", 32'(count), 32'd3);

    // start with an empty buffer does nothing
    do_clear();
    go();
    idle(3);

    // fill to DEPTH with load_valid held; 17th offer must be dropped
    for (int i = 0; i < DEPTH + 1; i++) load(9'((i * 37 + 1) & 9'h1FF), 8'((i * 13 + 7) & 8'hFF));
    idle(1);
    go();
    idle(DEPTH + 4);

    // abort on the second valid cycle, then replay from index 0
    do_clear();
    load(9'h001, 8'h11);
    load(9'h0A2, 8'h22);
    load(9'h143, 8'h33);
    load(9'h1E4, 8'h44);
    load(9'h085, 8'h55);
    go();
    idle(1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    go();
    idle(9);

    // clear beats a simultaneous load; a load beats a simultaneous start
    do_clear();
    load(9'h111, 8'hA1);
    load(9'h122, 8'hA2);
    step(1'b1, 9'h133, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 9'h144, 8'hA4, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    go();
    idle(4);

    // reset on the third cycle of a six-entry run
    do_clear();
    for (int i = 0; i < 6; i++) load(9'(9'h100 + i), 8'(8'hC0 + i));
    go();
    idle(2);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(10);

    check("leftover_issues", exp_q.size(), 32'd0);
    check("leftover_done", done_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
